// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: port indices, default flit width and flit type.
// Also used by the output arbiters, the routing logic and the crossbar.
package noc_pkg;

  localparam int NOC_DATA_WIDTH = 32;
  localparam int NUM_PORTS      = 5;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_W = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_t;

  typedef logic [NOC_DATA_WIDTH-1:0] flit_t;

endpackage

// File: rtl/noc_cts_rx.sv
// Receive-side handshake: write_en generation and the registered CTS acknowledge.
// Shared by every stage that receives flits under RTS/DCTS.
module noc_cts_rx (
  input  logic clk,
  input  logic rst,
  input  logic drts,
  input  logic full,
  output logic cts,
  output logic write_en
);

  // Handshake: the sender holds data and drts until it sees cts=1, then drops drts.
  // A flit is taken on the edge where drts=1, cts=0 and there is room; cts pulses
  // for exactly one cycle afterwards. The ~cts term masks the drts that is still
  // high during that pulse, so one request is never written twice.
  assign write_en = drts & ~cts & ~full;

  always_ff @(posedge clk) begin
    if (rst) begin
      cts <= 1'b0;
    end else begin
      cts <= write_en;
    end
  end

endmodule

// File: rtl/noc_input_fifo.sv
// noc_input_fifo: per-port input buffer of a 5-port mesh router (binary wrap-bit pointers).
// Define NOC_FIFO_ERR_EN to add a sticky err output flagging illegal pop requests.
module noc_input_fifo
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic                  CTS,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full
`ifdef NOC_FIFO_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]           rptr;
  logic [AW:0]           wptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NUM_PORTS-1:0]  rd_req;
  logic                  write_en;
  logic                  read_en;

  assign rd_req[PORT_N] = read_en_N;
  assign rd_req[PORT_E] = read_en_E;
  assign rd_req[PORT_W] = read_en_W;
  assign rd_req[PORT_S] = read_en_S;
  assign rd_req[PORT_L] = read_en_L;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (rptr == wptr);
  assign full  = (rptr[AW-1:0] == wptr[AW-1:0]) && (rptr[AW] != wptr[AW]);

  // Any number of grants counts as a single pop.
  assign read_en = (|rd_req) & ~empty;

  noc_cts_rx u_cts_rx (
    .clk      (clk),
    .rst      (rst),
    .drts     (DRTS),
    .full     (full),
    .cts      (CTS),
    .write_en (write_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (write_en) wptr <= wptr + PTR_ONE;
      if (read_en)  rptr <= rptr + PTR_ONE;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (write_en && !rst) begin
      mem[wptr[AW-1:0]] <= RX;
    end
  end

  assign Data_out = mem[rptr[AW-1:0]];

`ifdef NOC_FIFO_ERR_EN
  logic illegal_req;

  assign illegal_req = ($countones(rd_req) > 1) || ((|rd_req) && empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (illegal_req) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_input_fifo.sv
// Testbench for noc_input_fifo: directed handshake/fill/reset scenarios plus randomized
// traffic, checked against a queue-based reference model of the buffer.
module tb_noc_input_fifo;
  import noc_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] RX;
  logic          DRTS;
  logic          read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic          CTS;
  logic [DW-1:0] Data_out;
  logic          empty;
  logic          full;
`ifdef NOC_FIFO_ERR_EN
  logic          err;
`endif

  noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .DRTS      (DRTS),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .CTS       (CTS),
    .Data_out  (Data_out),
    .empty     (empty),
    .full      (full)
`ifdef NOC_FIFO_ERR_EN
    ,
    .err       (err)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic          cts_m;
  logic          err_m;
  logic          started;
  int            pops;
  int            checks;
  int            passed;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor + reference model. On each falling edge the DUT outputs are compared with
  // the model, then the model advances using the inputs that the next rising edge sees.
  always @(negedge clk) begin
    int n_rd;
    int occ;
    logic wr;
    logic rd;
    logic [DW-1:0] popped;
    n_rd = int'(read_en_N) + int'(read_en_E) + int'(read_en_W) + int'(read_en_S) + int'(read_en_L);
    occ  = exp_q.size();
    if (started) begin
      chk("cts", CTS, cts_m);
      chk("empty", empty, occ == 0);
      chk("full", full, occ == DEPTH);
`ifdef NOC_FIFO_ERR_EN
      chk("err", err, err_m);
`endif
    end
    if (rst) begin
      exp_q.delete();
      cts_m   = 1'b0;
      err_m   = 1'b0;
      pops    = 0;
      started = 1'b1;
    end else begin
      wr = DRTS && !cts_m && (occ < DEPTH);
      rd = (n_rd > 0) && (occ > 0);
      if ((n_rd > 1) || ((n_rd > 0) && (occ == 0))) err_m = 1'b1;
      if (rd) begin
        popped = exp_q.pop_front();
        if (started) chk("pop_data", Data_out, popped);
        pops++;
      end
      if (wr) exp_q.push_back(RX);
      cts_m = wr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // p selects one port (PORT_N..PORT_L); any other value releases all grants.
  task automatic set_rd(input int p);
    read_en_N = (p == int'(PORT_N));
    read_en_E = (p == int'(PORT_E));
    read_en_W = (p == int'(PORT_W));
    read_en_S = (p == int'(PORT_S));
    read_en_L = (p == int'(PORT_L));
  endtask

  // Upstream sender: hold RX/DRTS until CTS is seen, then drop DRTS after the next edge.
  task automatic send_flit(input logic [DW-1:0] d);
    logic got;
    got  = 1'b0;
    RX   = d;
    DRTS = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (CTS) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("cts_timeout", got, 1'b1);
    step();
    DRTS = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic          done;
  logic [DW-1:0] old_head;

  initial begin
    checks = 0; passed = 0; started = 1'b0;
    cts_m = 1'b0; err_m = 1'b0; pops = 0;
    rst = 1'b1; RX = '0; DRTS = 1'b0;
    set_rd(7);

    // Reset, then idle for 10 cycles.
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();

    // Single flit, then one pop from E.
    send_flit(32'hDEADBEEF);
    step();
    set_rd(int'(PORT_E));
    step();
    set_rd(7);
    repeat (3) step();

    // Fill to full; a held 5th request must wait until a slot is freed.
    for (int i = 1; i <= 4; i++) send_flit(DW'(i));
    RX = 32'd5;
    DRTS = 1'b1;
    repeat (6) step();
    set_rd(int'(PORT_N));
    step();
    set_rd(7);
    send_flit(32'd5);
    set_rd(int'(PORT_N));
    repeat (4) step();
    set_rd(7);
    repeat (2) step();

    // Wrap and concurrency: 20 flits while L pops whenever the FIFO is non-empty.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_flit(32'h100 + DW'(i));
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 600 && !(done && exp_q.size() == 0); c++) begin
          if (!empty && ($urandom_range(0, 3) != 0)) set_rd(int'(PORT_L));
          else set_rd(7);
          step();
        end
        set_rd(7);
      end
    join
    chk("wrap_drain", exp_q.size(), 0);
    repeat (2) step();

    // Randomized traffic with random gaps and random single-port grants.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_flit($urandom());
          repeat ($urandom_range(0, 2)) step();
        end
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 1500 && !(done && exp_q.size() == 0); c++) begin
          set_rd($urandom_range(0, 7));
          step();
        end
        set_rd(7);
      end
    join
    chk("rand_drain", exp_q.size(), 0);
    repeat (2) step();

    // Mid-operation reset with 3 flits stored and a pending request.
    if ((pops % DEPTH) == 0) begin
      send_flit(32'hC00);
      set_rd(int'(PORT_E));
      step();
      set_rd(7);
    end
    for (int i = 1; i <= 3; i++) send_flit(32'hC00 + DW'(i));
    chk("pre_rst_count", exp_q.size(), 3);
    old_head = exp_q[0];
    RX = 32'hC0FF;
    DRTS = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    DRTS = 1'b0;
    @(negedge clk);
    chk("rst_empty", empty, 1'b1);
    chk("rst_cts", CTS, 1'b0);
    chk("rst_head_gone", Data_out != old_head, 1'b1);
    step();
    repeat (2) step();

    // Illegal pops: read on empty, then two grants together on a non-empty FIFO.
    set_rd(int'(PORT_S));
    step();
    set_rd(7);
    repeat (2) step();
    send_flit(32'hE01);
    send_flit(32'hE02);
    read_en_N = 1'b1;
    read_en_W = 1'b1;
    step();
    set_rd(7);
    @(negedge clk);
    chk("multi_pop_one", exp_q.size(), 1);
    chk("multi_pop_head", Data_out, 32'hE02);
    step();
    set_rd(int'(PORT_W));
    step();
    set_rd(7);
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
